// File: rtl/credit_link_sender_pkg.sv
// Shared constants for the credit link sender: flit width, flit type codes
// and the packet-tracker state encoding.
package credit_link_sender_pkg;
    localparam int DW      = 32;
    localparam int PKT_LEN = 4;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] BODY = 2'b10;
    localparam logic [1:0] TAIL = 2'b11;

    typedef enum logic {PKT_IDLE, PKT_ACTIVE} pkt_state_t;

    // Flit type lives in the top two bits of every flit.
    function automatic logic [1:0] flit_type(input logic [DW-1:0] f);
        return f[DW-1:DW-2];
    endfunction
endpackage

// File: rtl/credit_link_sender_if.sv
// Upstream flit handshake, credit-return link and status bundle of the sender.
interface credit_link_sender_if
    import credit_link_sender_pkg::*;
#(
    parameter int CNT_W = 5
) ();
    logic             valid_i;
    logic [DW-1:0]    data_i;
    logic             ready_o;
    logic             valid_o;
    logic [DW-1:0]    data_o;
    logic             credit_upd_i;
    logic [CNT_W-1:0] credit_cnt_o;
    logic             pkt_active_o;
    logic             err_o;

    modport slave (
        input  valid_i, data_i, credit_upd_i,
        output ready_o, valid_o, data_o, credit_cnt_o, pkt_active_o, err_o
    );

    modport master (
        output valid_i, data_i, credit_upd_i,
        input  ready_o, valid_o, data_o, credit_cnt_o, pkt_active_o, err_o
    );
endinterface

// File: rtl/link_flit_fifo.sv
// Synchronous non-FWFT flit FIFO; rd_data is a register that holds between reads,
// head exposes the entry at the read pointer for lookahead decode.
module link_flit_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          wr, rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr    = wr_en & ~full;
    assign rd    = rd_en & ~empty;
    assign head  = mem[rp];

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (rd) begin
                rd_data <= mem[rp];
                rp      <= rp + AW'(1);
            end
            case ({wr, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/credit_link_sender.sv
// Credit-based flit transmitter: local FIFO, downstream credit counter,
// registered link output and HEAD/BODY/TAIL order checker.
module credit_link_sender
    import credit_link_sender_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CREDITS = 16,
    parameter int CNT_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    credit_link_sender_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic             full, empty, pop;
    logic [AW:0]      fifo_count;
    logic [DW-1:0]    head, rd_data;
    logic [CNT_W-1:0] credit_cnt;
    logic [CNT_W:0]   cr_sum;
    logic             overflow, order_err, valid_q, err_q;
    pkt_state_t       pkt_q, pkt_nxt;

    link_flit_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.valid_i),
        .wr_data (bus.data_i),
        .rd_en   (pop),
        .rd_data (rd_data),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // Credits returned this cycle only become usable next cycle.
    assign pop      = ~empty & (credit_cnt != '0);
    assign cr_sum   = {1'b0, credit_cnt} - (CNT_W+1)'(pop) + (CNT_W+1)'(bus.credit_upd_i);
    assign overflow = (cr_sum > (CNT_W+1)'(CREDITS));

    always_comb begin
        pkt_nxt   = pkt_q;
        order_err = 1'b0;
        if (pop) begin
            case (flit_type(head))
                HEAD: begin
                    order_err = (pkt_q == PKT_ACTIVE);
                    pkt_nxt   = PKT_ACTIVE;
                end
                BODY: order_err = (pkt_q == PKT_IDLE);
                TAIL: begin
                    order_err = (pkt_q == PKT_IDLE);
                    pkt_nxt   = PKT_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            credit_cnt <= CNT_W'(CREDITS);
            pkt_q      <= PKT_IDLE;
            err_q      <= 1'b0;
        end else begin
            valid_q    <= pop;
            credit_cnt <= overflow ? CNT_W'(CREDITS) : cr_sum[CNT_W-1:0];
            pkt_q      <= pkt_nxt;
            err_q      <= err_q | overflow | order_err;
        end
    end

    a_full_count: assert property (@(posedge clk) disable iff (rst)
        full == (fifo_count == (AW+1)'(DEPTH)));

    assign bus.ready_o      = ~full;
    assign bus.valid_o      = valid_q;
    assign bus.data_o       = rd_data;
    assign bus.credit_cnt_o = credit_cnt;
    assign bus.pkt_active_o = (pkt_q == PKT_ACTIVE);
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_credit_link_sender.sv
// Self-checking bench: table of packet vectors, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_credit_link_sender;
    import credit_link_sender_pkg::*;

    localparam int DEPTH   = 8;
    localparam int CREDITS = 16;
    localparam int CNT_W   = 5;

    logic clk, rst;
    credit_link_sender_if #(.CNT_W(CNT_W)) bus ();

    credit_link_sender #(.DEPTH(DEPTH), .CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests, fails, sent;

    // reference model state
    logic [DW-1:0] q[$];
    int            m_cr;
    bit            m_pkt, m_err, m_vld;
    logic [DW-1:0] m_data;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input int pl);
        return {t, 30'(pl)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.valid_i = 1'b0; bus.data_i = '0; bus.credit_upd_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        m_cr = CREDITS; m_pkt = 0; m_err = 0; m_vld = 0; m_data = '0;
        chk("rst_valid", 64'(bus.valid_o), 64'(0));
        chk("rst_data", 64'(bus.data_o), 64'(0));
        chk("rst_cnt", 64'(bus.credit_cnt_o), 64'(CREDITS));
        chk("rst_pkt", 64'(bus.pkt_active_o), 64'(0));
        chk("rst_err", 64'(bus.err_o), 64'(0));
        chk("rst_ready", 64'(bus.ready_o), 64'(1));
    endtask

    // One clock cycle: drive, check ready, advance model, compare outputs.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic u);
        bit push, pop;
        int nc;
        logic [1:0] t;
        bus.valid_i = v; bus.data_i = d; bus.credit_upd_i = u;
        #3;
        chk("ready", 64'(bus.ready_o), 64'(q.size() < DEPTH));
        push = v && (q.size() < DEPTH);
        pop  = (q.size() != 0) && (m_cr != 0);
        @(posedge clk); #1;
        if (pop) begin
            m_data = q.pop_front();
            t = m_data[DW-1:DW-2];
            if (t == HEAD) begin if (m_pkt) m_err = 1; m_pkt = 1; end
            else if (t == BODY) begin if (!m_pkt) m_err = 1; end
            else if (t == TAIL) begin if (!m_pkt) m_err = 1; m_pkt = 0; end
        end
        if (push) q.push_back(d);
        nc = m_cr - int'(pop) + int'(u);
        if (nc > CREDITS) begin nc = CREDITS; m_err = 1; end
        m_cr  = nc;
        m_vld = pop;
        if (bus.valid_o) sent++;
        chk("valid", 64'(bus.valid_o), 64'(m_vld));
        chk("data", 64'(bus.data_o), 64'(m_data));
        chk("credit", 64'(bus.credit_cnt_o), 64'(m_cr));
        chk("pkt", 64'(bus.pkt_active_o), 64'(m_pkt));
        chk("err", 64'(bus.err_o), 64'(m_err));
    endtask

    typedef struct {
        logic       v;
        logic [1:0] t;
        logic       u;
        logic       ev;
        logic [1:0] et;
        int         epl;
        int         ecnt;
        logic       epkt;
        logic       eerr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int s;
        logic [1:0] rt;
        tests = 0; fails = 0; sent = 0;
        rst = 1'b1;

        // 4-flit packet: HEAD BODY BODY TAIL, payloads 100..103
        tbl[0] = '{1, HEAD, 0, 0, 2'b00, 0,   16, 0, 0};
        tbl[1] = '{1, BODY, 0, 1, HEAD,  100, 15, 1, 0};
        tbl[2] = '{1, BODY, 0, 1, BODY,  101, 14, 1, 0};
        tbl[3] = '{1, TAIL, 0, 1, BODY,  102, 13, 1, 0};
        tbl[4] = '{0, BODY, 0, 1, TAIL,  103, 12, 0, 0};
        tbl[5] = '{0, BODY, 0, 0, TAIL,  103, 12, 0, 0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, mk(tbl[i].t, 100 + i), tbl[i].u);
            chk($sformatf("tbl%0d_valid", i), 64'(bus.valid_o), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), 64'(bus.data_o), 64'(mk(tbl[i].et, tbl[i].epl)));
            chk($sformatf("tbl%0d_cnt", i), 64'(bus.credit_cnt_o), 64'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_pkt", i), 64'(bus.pkt_active_o), 64'(tbl[i].epkt));
            chk($sformatf("tbl%0d_err", i), 64'(bus.err_o), 64'(tbl[i].eerr));
        end

        // credit exhaustion: 16 sent, FIFO fills, one credit releases one flit
        do_reset();
        sent = 0;
        for (int i = 0; i < 30; i++) step(1'b1, mk(i == 0 ? HEAD : BODY, i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        chk("exh_sent", 64'(sent), 64'(16));
        chk("exh_cnt", 64'(bus.credit_cnt_o), 64'(0));
        chk("exh_ready", 64'(bus.ready_o), 64'(0));
        sent = 0;
        step(1'b0, '0, 1'b1);
        chk("pulse_t1_valid", 64'(bus.valid_o), 64'(0));
        step(1'b0, '0, 1'b0);
        chk("pulse_t2_valid", 64'(bus.valid_o), 64'(1));
        chk("pulse_t2_data", 64'(bus.data_o), 64'(mk(BODY, 16)));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        chk("pulse_sent", 64'(sent), 64'(1));

        // pop and credit return every cycle
        do_reset();
        step(1'b1, mk(HEAD, 0), 1'b0);
        sent = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, mk(i == 10 ? TAIL : BODY, i), 1'b1);
            chk("steady_cnt", 64'(bus.credit_cnt_o), 64'(CREDITS));
        end
        chk("steady_sent", 64'(sent), 64'(10));
        chk("steady_err", 64'(bus.err_o), 64'(0));
        step(1'b0, '0, 1'b0);

        // credit overflow while idle is sticky until reset
        do_reset();
        step(1'b0, '0, 1'b1);
        chk("ovf_cnt", 64'(bus.credit_cnt_o), 64'(CREDITS));
        chk("ovf_err", 64'(bus.err_o), 64'(1));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        chk("ovf_sticky", 64'(bus.err_o), 64'(1));

        // order violations: BODY HEAD HEAD TAIL
        do_reset();
        sent = 0;
        step(1'b1, mk(BODY, 1), 1'b0);
        step(1'b1, mk(HEAD, 2), 1'b0);
        chk("ord_first_err", 64'(bus.err_o), 64'(1));
        step(1'b1, mk(HEAD, 3), 1'b0);
        step(1'b1, mk(TAIL, 4), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        chk("ord_sent", 64'(sent), 64'(4));
        chk("ord_pkt", 64'(bus.pkt_active_o), 64'(0));

        // reset mid-packet with flits queued
        do_reset();
        for (int i = 0; i < 21; i++) step(1'b1, mk(i == 0 ? HEAD : BODY, i), 1'b0);
        chk("mid_pkt", 64'(bus.pkt_active_o), 64'(1));
        do_reset();
        sent = 0;
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
        chk("mid_no_stale", 64'(sent), 64'(0));

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            s  = int'($urandom_range(0, 2));
            rt = (s == 0) ? HEAD : (s == 1) ? BODY : TAIL;
            step(($urandom_range(0, 9) < 7), mk(rt, int'($urandom_range(0, 1000))),
                 ($urandom_range(0, 9) < 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
